// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier scheduler.
//   MULT_N    : default operand width
//   MULT_NREQ : default number of requesters
//   MULT_TMO  : default RUN-cycle budget before a timeout response
//   state_t   : scheduler FSM states
//   id_width  : width of a requester index (at least 1 bit)
package mult_pkg;

  localparam int MULT_N    = 256;
  localparam int MULT_NREQ = 4;
  localparam int MULT_TMO  = 300;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    RESP
  } state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector, one bit per requester
//   ptr : highest-priority requester index for this decision
//   gnt : one-hot grant, all zero when no request is set
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = MULT_NREQ,
  parameter int IW   = id_width(MULT_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic found;
  int   idx;

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Multiplier scheduler: arbitrates NREQ requesters onto one external
// sequential multiplier, sequences its reset/enable, and returns the
// product (or a timeout error) to the consumer.
//   clk, rst_n             : clock, synchronous active-low reset
//   req_valid/req_ready    : per-requester handshake (one-hot ready)
//   req_a, req_b           : packed operands, requester i at [i*N +: N]
//   rsp_valid/rsp_ready    : response handshake
//   rsp_id/rsp_prod/rsp_err: owner index, product, timeout flag
//   mul_en, mul_rst_n      : multiplier enable / reset
//   mul_a, mul_b           : multiplier operands
//   mul_prod, mul_rdy      : multiplier product / data ready
module mult_sched
  import mult_pkg::*;
#(
  parameter int N    = MULT_N,
  parameter int NREQ = MULT_NREQ,
  parameter int TMO  = MULT_TMO,
  localparam int IW  = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [2*N-1:0]    rsp_prod,
  output logic              rsp_err,
  output logic              mul_en,
  output logic              mul_rst_n,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  input  logic [2*N-1:0]    mul_prod,
  input  logic              mul_rdy
);

  localparam int CW = $clog2(TMO + 1);

  state_t          state, state_next;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            hs;
  logic            rdy_ok;
  logic            tmo_hit;
  logic [N-1:0]    a_arr [NREQ];
  logic [N-1:0]    b_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_arr[gi] = req_a[gi*N +: N];
    assign b_arr[gi] = req_b[gi*N +: N];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt[k]) gnt_idx = IW'(k);
    end
  end

  // Control outputs decode straight from state, gated by reset so they
  // read as idle while rst_n is low.
  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;
  assign hs        = |(req_valid & req_ready);
  assign mul_en    = rst_n && (state == RUN);
  assign mul_rst_n = rst_n && (state != CLEAR);
  assign rsp_valid = rst_n && (state == RESP);

  // A data_rdy seen in the first RUN cycle may be left over from the
  // previous operation, so only cnt>=1 qualifies.
  assign rdy_ok  = mul_rdy && (cnt != '0);
  assign tmo_hit = (cnt == CW'(TMO - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hs) state_next = CLEAR;
      CLEAR:   state_next = RUN;
      RUN:     if (rdy_ok || tmo_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      rsp_id   <= '0;
      rsp_prod <= '0;
      rsp_err  <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (hs) begin
            mul_a  <= a_arr[gnt_idx];
            mul_b  <= b_arr[gnt_idx];
            rsp_id <= gnt_idx;
            ptr    <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            cnt    <= '0;
          end
        end
        CLEAR: cnt <= '0;
        RUN: begin
          cnt <= cnt + CW'(1);
          if (rdy_ok) begin
            rsp_prod <= mul_prod;
            rsp_err  <= 1'b0;
          end else if (tmo_hit) begin
            rsp_prod <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Testbench for mult_sched with a behavioural sequential-multiplier model
// and a scoreboard of expected responses.
module tb_mult_sched;
  import mult_pkg::*;

  localparam int N    = MULT_N;
  localparam int NREQ = MULT_NREQ;
  localparam int TMO  = MULT_TMO;
  localparam int IW   = id_width(NREQ);
  localparam int W2   = 2 * N;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [W2-1:0]     rsp_prod;
  logic              rsp_err;
  logic              mul_en, mul_rst_n;
  logic [N-1:0]      mul_a, mul_b;
  logic [W2-1:0]     mul_prod;
  logic              mul_rdy;

  logic [N-1:0] a_op [NREQ];
  logic [N-1:0] b_op [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = a_op[i];
      req_b[i*N +: N] = b_op[i];
    end
  end

  mult_sched #(.N(N), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_err   (rsp_err),
    .mul_en    (mul_en),
    .mul_rst_n (mul_rst_n),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_prod  (mul_prod),
    .mul_rdy   (mul_rdy)
  );

  // Multiplier model: data_rdy rises after lat enabled cycles. In stale
  // mode its reset leaves the old rdy/product in place.
  int            lat       = 1;
  bit            never_rdy = 1'b0;
  bit            stale     = 1'b0;
  logic          m_rdy     = 1'b0;
  logic [W2-1:0] m_prod    = '0;
  int            m_cnt     = 0;

  assign mul_rdy  = m_rdy;
  assign mul_prod = m_prod;

  always @(posedge clk) begin
    if (!mul_rst_n) begin
      if (!stale) begin
        m_rdy  <= 1'b0;
        m_prod <= '0;
      end
      m_cnt <= 0;
    end else if (mul_en && !never_rdy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 >= lat) begin
        m_rdy  <= 1'b1;
        m_prod <= {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};
      end
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_val(input string tag, input logic [W2-1:0] got,
                           input logic [W2-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W2-1:0] z1(input logic b);
    return {{(W2-1){1'b0}}, b};
  endfunction
  function automatic logic [W2-1:0] zr(input logic [NREQ-1:0] v);
    return {{(W2-NREQ){1'b0}}, v};
  endfunction
  function automatic logic [W2-1:0] zi(input logic [IW-1:0] v);
    return {{(W2-IW){1'b0}}, v};
  endfunction
  function automatic logic [W2-1:0] zn(input logic [N-1:0] v);
    return {{N{1'b0}}, v};
  endfunction

  function automatic logic [N-1:0] rnd_n();
    logic [N-1:0] r;
    r = '0;
    for (int w = 0; w < N / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  typedef struct {
    logic [IW-1:0] id;
    logic [W2-1:0] prod;
    logic          err;
    int            run;
  } exp_t;

  exp_t sb[$];

  // Monitor: predicts grants, tracks the operation in flight and checks
  // every response against the scoreboard. Sampled on the falling edge.
  int            ptr_m     = 0;
  bit            busy      = 1'b0;
  int            run_cnt   = 0;
  int            clr_cnt   = 0;
  logic [N-1:0]  cur_a, cur_b;
  bit            prev_hold = 1'b0;
  logic [IW-1:0] prev_id;
  logic [W2-1:0] prev_prod;
  logic          prev_err;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rr;
    int              pick;
    exp_t            e;
    if (!rst_n) begin
      sb.delete();
      ptr_m     = 0;
      busy      = 1'b0;
      prev_hold = 1'b0;
    end else begin
      exp_rr = '0;
      pick   = rr_pick(req_valid, ptr_m);
      if (!busy && pick >= 0) exp_rr[pick] = 1'b1;
      check_val("req_ready", zr(req_ready), zr(exp_rr));
      if (!busy) begin
        if (pick >= 0) begin
          e.id   = IW'(pick);
          e.err  = never_rdy;
          e.prod = never_rdy ? '0 : zn(a_op[pick]) * zn(b_op[pick]);
          e.run  = never_rdy ? TMO : lat + 1;
          sb.push_back(e);
          cur_a   = a_op[pick];
          cur_b   = b_op[pick];
          ptr_m   = (pick + 1) % NREQ;
          busy    = 1'b1;
          run_cnt = 0;
          clr_cnt = 0;
        end
        if (rsp_valid) check_val("spurious_rsp", z1(rsp_valid), z1(1'b0));
      end else begin
        if (mul_en) begin
          run_cnt++;
          check_val("mul_a_hold", zn(mul_a), zn(cur_a));
          check_val("mul_b_hold", zn(mul_b), zn(cur_b));
        end
        if (!mul_rst_n) clr_cnt++;
        if (prev_hold) begin
          check_val("hold_valid", z1(rsp_valid), z1(1'b1));
          check_val("hold_id", zi(rsp_id), zi(prev_id));
          check_val("hold_prod", rsp_prod, prev_prod);
          check_val("hold_err", z1(rsp_err), z1(prev_err));
        end
        if (rsp_valid && rsp_ready && sb.size() > 0) begin
          e = sb.pop_front();
          $display("rsp id=%0d err=%0b run=%0d prod=%0h", rsp_id, rsp_err,
                   run_cnt, rsp_prod);
          check_val("rsp_id", zi(rsp_id), zi(e.id));
          check_val("rsp_prod", rsp_prod, e.prod);
          check_val("rsp_err", z1(rsp_err), z1(e.err));
          check_val("run_cycles", W2'(run_cnt), W2'(e.run));
          check_val("clear_cycles", W2'(clr_cnt), W2'(1));
          busy = 1'b0;
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_id   = rsp_id;
      prev_prod = rsp_prod;
      prev_err  = rsp_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop each requester's valid after its handshake and scramble its
  // operands so later changes cannot leak into the operation.
  task automatic wait_grants();
    logic [NREQ-1:0] hs;
    int b = 0;
    while (req_valid != '0 && b < 3000) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~hs;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin
          a_op[i] = rnd_n();
          b_op[i] = rnd_n();
        end
      end
      b++;
    end
    if (req_valid != '0) check_val("grant_timeout", zr(req_valid), zr('0));
  endtask

  task automatic wait_done();
    int b = 0;
    while ((sb.size() != 0 || rsp_valid) && b < 1000) begin
      tick();
      b++;
    end
    if (b >= 1000) check_val("rsp_timeout", W2'(sb.size()), W2'(0));
  endtask

  task automatic check_reset_outputs();
    check_val("rst_req_ready", zr(req_ready), zr('0));
    check_val("rst_rsp_valid", z1(rsp_valid), z1(1'b0));
    check_val("rst_rsp_err", z1(rsp_err), z1(1'b0));
    check_val("rst_rsp_id", zi(rsp_id), zi('0));
    check_val("rst_rsp_prod", rsp_prod, '0);
    check_val("rst_mul_en", z1(mul_en), z1(1'b0));
    check_val("rst_mul_rst_n", z1(mul_rst_n), z1(1'b0));
    check_val("rst_mul_a", zn(mul_a), zn('0));
    check_val("rst_mul_b", zn(mul_b), zn('0));
  endtask

  initial begin
    int b;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    repeat (3) tick();
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    // Single request: 5 * 12 = 0x3c.
    a_op[0] = N'(5);
    b_op[0] = N'(12);
    req_valid = 4'b0001;
    wait_grants();
    wait_done();

    // Contention from ptr=0: all-ones * 2 for every requester.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    lat = 3;
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = '1;
      b_op[i] = N'(2);
    end
    req_valid = '1;
    wait_grants();
    wait_done();

    // Backpressure with another requester waiting.
    lat       = 2;
    rsp_ready = 1'b0;
    a_op[1]   = N'(1000);
    b_op[1]   = N'(77);
    req_valid = 4'b0010;
    wait_grants();
    b = 0;
    while (!rsp_valid && b < 100) begin
      tick();
      b++;
    end
    if (b >= 100) check_val("bp_rsp_wait", z1(rsp_valid), z1(1'b1));
    a_op[2]   = N'(6);
    b_op[2]   = N'(7);
    req_valid = 4'b0100;
    repeat (10) tick();
    rsp_ready = 1'b1;
    wait_grants();
    wait_done();

    // Timeout: multiplier never signals ready.
    never_rdy = 1'b1;
    a_op[3]   = N'(9);
    b_op[3]   = N'(9);
    req_valid = 4'b1000;
    wait_grants();
    wait_done();
    never_rdy = 1'b0;

    // Leave a distinct product and a high rdy in the multiplier model.
    lat       = 1;
    a_op[0]   = N'(7);
    b_op[0]   = N'(9);
    req_valid = 4'b0001;
    wait_grants();
    wait_done();

    // Stale ready held across CLEAR must not be taken at cnt=0.
    stale     = 1'b1;
    a_op[1]   = '1;
    b_op[1]   = '1;
    req_valid = 4'b0010;
    wait_grants();
    wait_done();
    stale = 1'b0;

    // Reset during RUN aborts without a response.
    lat       = 20;
    a_op[0]   = N'(11);
    b_op[0]   = N'(13);
    req_valid = 4'b0001;
    wait_grants();
    b = 0;
    while (!mul_en && b < 50) begin
      tick();
      b++;
    end
    if (b >= 50) check_val("midrst_run_wait", z1(mul_en), z1(1'b1));
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs();
    rst_n = 1'b1;
    lat   = 1;
    repeat (10) tick();

    // Arbitration restarts at ptr=0: requester 0 wins over 1.
    a_op[0]   = N'(3);
    b_op[0]   = N'(4);
    a_op[1]   = N'(21);
    b_op[1]   = N'(2);
    req_valid = 4'b0011;
    wait_grants();
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 The block SHALL have parameter N, default 256, giving the operand width.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters.
REQ-003 The block SHALL have parameter TMO, default 300, giving the maximum number of RUN cycles before timeout.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  NREQ  per-requester operation request.
REQ-007 req_ready  out  NREQ  one-hot grant/accept.
REQ-008 req_a, req_b  in  NREQ*N each  packed operands; requester i occupies bits [i*N +: N].
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer accepts result.
REQ-011 rsp_id  out  $clog2(NREQ)  index of the requester that owns the result.
REQ-012 rsp_prod  out  2N  product.
REQ-013 rsp_err  out  1  timeout flag.
REQ-014 mul_en, mul_rst_n  out  1 each  drive the multiplier's en and rst_n.
REQ-015 mul_a, mul_b  out  N each  multiplier operands.
REQ-016 mul_prod  in  2N  multiplier product.
REQ-017 mul_rdy  in  1  multiplier data_rdy.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, RUN and RESP.
REQ-019 IDLE: req_ready SHALL be asserted for exactly one requester, selected by round-robin from pointer ptr among those with req_valid=1; req_ready SHALL be all zero if no req_valid is set.
REQ-020 On handshake (req_valid[i] & req_ready[i]), the block SHALL register operands into mul_a/mul_b, set id=i and ptr=(i+1) mod NREQ, and go to CLEAR.
REQ-021 CLEAR lasts exactly 1 cycle: mul_rst_n=0 and mul_en=0, then the FSM SHALL go to RUN.
REQ-022 RUN: mul_rst_n=1 and mul_en=1, mul_a/mul_b SHALL be held stable, and cycle counter cnt SHALL increment from 0.
REQ-023 mul_rdy SHALL be ignored in the first RUN cycle (cnt=0) to reject a stale data_rdy from the prior operation.
REQ-024 When mul_rdy=1 and cnt>=1, the block SHALL capture rsp_prod=mul_prod and rsp_err=0, deassert mul_en, and go to RESP.
REQ-025 When cnt reaches TMO without a qualifying mul_rdy, the block SHALL set rsp_prod=0 and rsp_err=1 and go to RESP.
REQ-026 RESP: rsp_valid=1, and rsp_id/rsp_prod/rsp_err SHALL stay stable until rsp_ready=1, after which the FSM goes to IDLE on the next cycle; no new request SHALL be accepted in the same cycle.
REQ-027 Changes to req_valid or req_a/req_b outside the handshake cycle SHALL NOT affect an operation in flight.
REQ-028 Minimum request-to-rsp_valid latency SHALL be 1 (CLEAR) + k (RUN cycles until qualifying mul_rdy) + 1 cycles.
REQ-029 Grants SHALL be starvation-free: a continuously valid requester is granted within NREQ grants.

Reset
REQ-030 While rst_n=0, the block SHALL force state=IDLE, ptr=0, cnt=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_prod=0, mul_en=0, mul_rst_n=0, mul_a=0, mul_b=0.
REQ-031 Reset asserted in CLEAR, RUN or RESP SHALL abort the operation with no response; after release, arbitration resumes from ptr=0.

Structure
REQ-032 Package mult_pkg SHALL hold the state enum, default N and NREQ, and the TMO default.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr; output one-hot gnt), purely combinational.
REQ-034 mult_sched SHALL NOT instantiate seq_mult; top-level wiring connects the mul_* ports to it.

Verification
REQ-035 Single request: req 0, a=5, b=12 -> CLEAR pulse, then rsp_valid with rsp_id=0, rsp_prod=0x3c, rsp_err=0.
REQ-036 Contention: all four valid at once, ptr=0 -> grants in order 0,1,2,3; with a=all-ones and b=2 each product is 0x1ff..fe (2N bits).
REQ-037 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and its data held stable, req_ready=0 throughout, and no second grant.
REQ-038 Timeout: multiplier model never raises mul_rdy -> rsp_err=1 and rsp_prod=0 after exactly TMO RUN cycles.
REQ-039 Stale ready: mul_rdy held high across CLEAR -> not accepted at cnt=0; a=all-ones and b=all-ones still yields 0xff..fe00..01.
REQ-040 Mid-operation reset: rst_n low for 2 cycles during RUN -> all outputs at reset values and no response; the next request (a=3, b=4) returns 0xc.
